// File: rtl/pos_packet_pkg.sv
// pos_packet_pkg: packet FSM states, packet lengths and default framing bytes
// shared between the position sender and the receiving aggregator.
package pos_packet_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_CMD, ST_XL, ST_XH, ST_YL, ST_YH, ST_CHK, ST_DONE
    } pkt_state_t;
    localparam int PKT_LEN = 6;
    localparam int PKT_LEN_CHK = 7;
    localparam logic [7:0] DEF_HEADER = 8'hF5;
    localparam logic [7:0] DEF_CMD = 8'h03;
    localparam int DIV_W = 24;
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer; byte_done is high in the last cycle of the
// stop bit so the next start can be loaded with no idle gap.
module uart_byte_tx
    import pos_packet_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic [7:0]       data_byte,
    input  logic [DIV_W-1:0] divisor,
    output logic             tx,
    output logic             byte_done
);
    logic [9:0] sh;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] baud;
    logic [3:0] bits;
    logic busy;
    logic bit_end;
    assign bit_end = busy && baud == div_q - DIV_W'(1);
    assign byte_done = bit_end && bits == 4'd9;
    assign tx = sh[0];
    // Shifting in ones leaves the line idle-high once the frame has gone out.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            sh <= '1;
            div_q <= DIV_W'(2);
            baud <= '0;
            bits <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sh <= {1'b1, data_byte, 1'b0};
            div_q <= divisor;
            baud <= '0;
            bits <= '0;
            busy <= 1'b1;
        end else if (bit_end) begin
            sh <= {1'b1, sh[9:1]};
            baud <= '0;
            bits <= bits + 4'd1;
            busy <= bits != 4'd9;
        end else if (busy)
            baud <= baud + DIV_W'(1);
endmodule

// File: rtl/pos_packet_sender.sv
// pos_packet_sender: sends HEADER, CMD, X LSB/MSB, Y LSB/MSB as back-to-back 8N1 bytes.
// Define PACKET_CHECKSUM_EN to append an XOR checksum byte before DONE.
module pos_packet_sender
    import pos_packet_pkg::*;
#(
    parameter logic [7:0] HEADER_VAL = DEF_HEADER,
    parameter logic [7:0] CMD_VAL = DEF_CMD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [30:0] i_setup,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic        o_uart_tx,
    output logic        o_done
);
    pkt_state_t state, nxt;
    logic [31:0] data_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] tx_div;
    logic [7:0] tx_byte;
    logic [7:0] chk;
    logic accept;
    logic tx_start;
    logic byte_done;
    logic unused_setup;
    assign unused_setup = ^i_setup[30:24];
    assign accept = state == ST_IDLE && i_valid;
    assign chk = HEADER_VAL ^ CMD_VAL ^ data_q[7:0] ^ data_q[15:8] ^ data_q[23:16] ^ data_q[31:24];
    assign tx_start = accept || (byte_done && nxt != ST_DONE);
    assign tx_div = accept ? clamp_div(i_setup[23:0]) : div_q;
    always_comb begin
        case (state)
            ST_HDR: nxt = ST_CMD;
            ST_CMD: nxt = ST_XL;
            ST_XL: nxt = ST_XH;
            ST_XH: nxt = ST_YL;
            ST_YL: nxt = ST_YH;
`ifdef PACKET_CHECKSUM_EN
            ST_YH: nxt = ST_CHK;
`else
            ST_YH: nxt = ST_DONE;
`endif
            ST_CHK: nxt = ST_DONE;
            default: nxt = ST_IDLE;
        endcase
        case (nxt)
            ST_CMD: tx_byte = CMD_VAL;
            ST_XL: tx_byte = data_q[7:0];
            ST_XH: tx_byte = data_q[15:8];
            ST_YL: tx_byte = data_q[23:16];
            ST_YH: tx_byte = data_q[31:24];
            ST_CHK: tx_byte = chk;
            default: tx_byte = HEADER_VAL;
        endcase
        if (accept)
            tx_byte = HEADER_VAL;
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state <= ST_IDLE;
            data_q <= '0;
            div_q <= DIV_W'(2);
            o_ready <= 1'b1;
            o_done <= 1'b0;
        end else
            case (state)
                ST_IDLE:
                    if (i_valid) begin
                        state <= ST_HDR;
                        data_q <= i_data;
                        div_q <= clamp_div(i_setup[23:0]);
                        o_ready <= 1'b0;
                    end
                ST_DONE: begin
                    state <= ST_IDLE;
                    o_done <= 1'b0;
                    o_ready <= 1'b1;
                end
                default:
                    if (byte_done) begin
                        state <= nxt;
                        o_done <= nxt == ST_DONE;
                    end
            endcase
    uart_byte_tx u_tx (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .start(tx_start),
        .data_byte(tx_byte),
        .divisor(tx_div),
        .tx(o_uart_tx),
        .byte_done(byte_done)
    );
endmodule

// File: tb/tb_pos_packet_sender.sv
// tb_pos_packet_sender: scoreboard bench; a line decoder and o_done monitor pop
// expected bytes and done cycles queued by the stimulus.
module tb_pos_packet_sender;
`ifdef PACKET_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic [30:0] i_setup = '0;
    logic i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic o_ready, o_uart_tx, o_done;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mon_div = 4;
    logic [7:0] exp_q[$];
    int done_q[$];
    logic m_busy = 1'b0;
    logic m_bad = 1'b0;
    logic m_cur = 1'b0;
    logic [9:0] m_sh = '0;
    logic [7:0] m_exp;
    int m_bit = 0;
    int m_cnt = 0;
    int a1, a2, a3;

    always #5 i_clk = ~i_clk;

    pos_packet_sender dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_setup(i_setup),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_uart_tx(o_uart_tx),
        .o_done(o_done)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Line decoder and done monitor, sampled 1 time unit after each rising edge.
    always begin
        @(posedge i_clk);
        cyc++;
        #1;
        if (i_rst)
            m_busy = 1'b0;
        else if (!m_busy) begin
            if (!o_uart_tx) begin
                m_busy = 1'b1;
                m_bit = 0;
                m_cnt = 1;
                m_cur = 1'b0;
                m_bad = 1'b0;
            end
        end else begin
            if (m_cnt == 0)
                m_cur = o_uart_tx;
            else if (o_uart_tx !== m_cur)
                m_bad = 1'b1;
            m_cnt++;
        end
        if (m_busy && m_cnt == mon_div) begin
            m_sh[m_bit] = m_cur;
            m_bit++;
            m_cnt = 0;
            if (m_bit == 10) begin
                m_busy = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL line_byte: unexpected byte %0h on line", m_sh[8:1]);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("line_frame", {m_bad, m_sh}, {1'b0, 1'b1, m_exp, 1'b0});
                end
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_pulse: unexpected o_done at cycle %0d", cyc);
            end else
                check("done_cycle", cyc, done_q.pop_front());
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [31:0] d, input logic [23:0] s, input bit keep, output int acc);
        logic [7:0] x;
        i_data = d;
        i_setup = {7'h55, s};
        i_valid = 1'b1;
        mon_div = (s < 2) ? 2 : int'(s);
        for (int n = 0; n < 5000 && !o_ready; n++)
            @(negedge i_clk);
        if (!o_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: o_ready never rose, required 1");
            i_valid = 1'b0;
            acc = -1;
            return;
        end
        x = 8'hF5 ^ 8'h03 ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        exp_q.push_back(8'hF5);
        exp_q.push_back(8'h03);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[31:24]);
        if (NB == 7)
            exp_q.push_back(x);
        @(posedge i_clk);
        #1;
        acc = cyc;
        done_q.push_back(acc + 10 * NB * mon_div);
        @(negedge i_clk);
        if (!keep)
            i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 5000 && (exp_q.size() != 0 || done_q.size() != 0); n++)
            @(negedge i_clk);
        check("drain", exp_q.size() + done_q.size(), 0);
        repeat (50) @(negedge i_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_tx", o_uart_tx, 1);
        check("rst_ready", o_ready, 1);
        check("rst_done", o_done, 0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        send(32'h0201_0403, 24'd4, 0, a1);
        check("latency_start", o_uart_tx, 0);
        check("busy_ready", o_ready, 0);
        wait_idle();

        // i_valid held high across two packets.
        send(32'h1234_5678, 24'd4, 1, a1);
        send(32'hDEAD_BEEF, 24'd4, 0, a2);
        check("b2b_gap", a2 - a1, 10 * NB * 4 + 2);
        wait_idle();

        // Request pulsed during the X MSB byte is ignored.
        send(32'h1122_3344, 24'd4, 0, a1);
        repeat (129) @(negedge i_clk);
        i_valid = 1'b1;
        check("xh_ready", o_ready, 0);
        @(negedge i_clk);
        check("xh_ready2", o_ready, 0);
        i_valid = 1'b0;
        wait_idle();

        // Reset during the Y LSB start bit aborts the packet.
        send(32'h0201_0403, 24'd4, 0, a1);
        repeat (161) @(negedge i_clk);
        check("yl_start", o_uart_tx, 0);
        i_rst = 1'b1;
        #1;
        check("abort_tx", o_uart_tx, 1);
        check("abort_ready", o_ready, 1);
        check("abort_done", o_done, 0);
        exp_q.delete();
        done_q.delete();
        i_valid = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_hold_tx", o_uart_tx, 1);
        i_rst = 1'b0;
        a3 = cyc;
        send(32'hCAFE_0102, 24'd4, 0, a1);
        check("release_accept", a1, a3 + 1);
        wait_idle();

        // Divisor 0 clamps to 2.
        send(32'hA5C3_0F81, 24'd0, 0, a1);
        wait_idle();
        send(32'h0F0F_F0F0, 24'd1, 0, a1);
        wait_idle();

        // Setup change mid-packet leaves the packet at the latched divisor.
        send(32'h8001_7E55, 24'd6, 0, a1);
        repeat (100) @(negedge i_clk);
        i_setup = {7'h00, 24'd3};
        i_data = 32'hFFFF_FFFF;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
